// File: rtl/bpred_unit.sv
// Branch prediction unit: 2-bit BHT, tagged BTB with type field, perf counters.
// Optional return address stack is compiled in when BP_RAS_EN is defined.
module bpred_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int IDX_BITS  = 6,
  parameter int TAG_BITS  = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                ex_valid,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic                ex_is_branch,
  input  logic                ex_is_jump,
  input  logic                ex_is_call,
  input  logic                ex_is_ret,
  input  logic                ex_taken,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic                ex_pred_taken,
  input  logic [PC_WIDTH-1:0] ex_pred_target,
  output logic                ex_mispredict,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispredicts
);

  localparam int DEPTH   = 1 << IDX_BITS;
  localparam int TAG_LSB = IDX_BITS + 2;
  localparam int TAG_MSB = IDX_BITS + TAG_BITS + 1;

  typedef enum logic [1:0] {
    T_BRANCH = 2'b00,
    T_JUMP   = 2'b01,
    T_RET    = 2'b10
  } btb_type_e;

  logic [1:0]          bht        [DEPTH];
  logic [DEPTH-1:0]    btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [DEPTH];
  logic [PC_WIDTH-1:0] btb_target [DEPTH];
  btb_type_e           btb_type   [DEPTH];
  logic [31:0]         perf_branches_q;
  logic [31:0]         perf_mispredicts_q;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit;
  logic                ex_cf;
  btb_type_e           ex_type;

  assign if_idx  = if_pc[TAG_LSB-1:2];
  assign if_tag  = if_pc[TAG_MSB:TAG_LSB];
  assign ex_idx  = ex_pc[TAG_LSB-1:2];
  assign ex_tag  = ex_pc[TAG_MSB:TAG_LSB];
  assign ex_cf   = ex_is_branch | ex_is_jump;
  assign ex_type = ex_is_ret ? T_RET : (ex_is_jump ? T_JUMP : T_BRANCH);
  assign if_hit  = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);

`ifdef BP_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr;
  logic [CNT_W-1:0]    ras_count;
  logic [PC_WIDTH-1:0] ras_top, ras_link;
  logic                ras_push, ras_pop;

  assign ras_top  = ras_mem[ras_ptr - PTR_W'(1)];
  assign ras_link = ex_pc + PC_WIDTH'(4);
  assign ras_push = ex_valid && ex_is_call;
  assign ras_pop  = ex_valid && ex_is_ret;

  // ras_ptr is the next free slot; wrapping it makes a full push overwrite the oldest entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (ras_push && !ras_pop) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_count != CNT_W'(RAS_DEPTH)) ras_count <= ras_count + CNT_W'(1);
    end else if (ras_pop && !ras_push && ras_count != '0) begin
      ras_ptr   <= ras_ptr - PTR_W'(1);
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (ras_push && ras_pop) ras_mem[ras_ptr - PTR_W'(1)] <= ras_link;
    else if (ras_push)       ras_mem[ras_ptr]             <= ras_link;
  end

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[PC_WIDTH-1:TAG_MSB+1]};
`else
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[PC_WIDTH-1:TAG_MSB+1],
                         ex_pc[1:0], ex_pc[PC_WIDTH-1:TAG_MSB+1], ex_is_call};
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = btb_target[if_idx];
    if (if_hit) begin
      pred_taken = (btb_type[if_idx] != T_BRANCH) || bht[if_idx][1];
`ifdef BP_RAS_EN
      if (btb_type[if_idx] == T_RET && ras_count != '0) pred_target = ras_top;
`endif
    end
  end

  // Gated by aresetn so an EX instruction in flight cannot redirect during reset.
  always_comb begin
    ex_mispredict = 1'b0;
    if (aresetn && ex_valid) begin
      if (ex_cf)
        ex_mispredict = (ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target));
      else
        ex_mispredict = ex_pred_taken;
    end
  end

  // NOTE: only the small control tables are reset; BTB tag/target payload is masked by valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
      btb_valid          <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else if (ex_valid) begin
      // NOTE: sequential state is always assigned with <= so all updates see pre-edge values.
      if (ex_is_branch) begin
        if (ex_taken && bht[ex_idx] != 2'b11)       bht[ex_idx] <= bht[ex_idx] + 2'd1;
        else if (!ex_taken && bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
      if (ex_cf && ex_taken)            btb_valid[ex_idx] <= 1'b1;
      else if (!ex_cf && ex_pred_taken) btb_valid[ex_idx] <= 1'b0;
      if (ex_cf && perf_branches_q != '1)
        perf_branches_q <= perf_branches_q + 32'd1;
      if (ex_mispredict && perf_mispredicts_q != '1)
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (ex_valid && ex_cf && ex_taken) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_target;
      btb_type[ex_idx]   <= ex_type;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_bpred_unit.sv
// Directed self-checking bench for bpred_unit: BHT training, aliasing, RAS,
// mispredict detection, counter saturation and asynchronous reset.
module tb_bpred_unit;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_is_call, ex_is_ret;
  logic        ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] perf_branches, perf_mispredicts;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  bpred_unit dut (
    .aclk(aclk), .aresetn(aresetn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_is_call(ex_is_call), .ex_is_ret(ex_is_ret),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_mispredict(ex_mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 = alu, 1 = branch, 2 = jump, 3 = call, 4 = ret, 5 = call+ret
  task automatic drive(input logic v, input logic [31:0] pc, input int kind, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_is_branch   = (kind == 1);
    ex_is_jump     = (kind >= 2);
    ex_is_call     = (kind == 3) || (kind == 5);
    ex_is_ret      = (kind == 4) || (kind == 5);
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    #1;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] ret_exp [5];
  logic [31:0] top_after_cr;

  initial begin
`ifdef BP_RAS_EN
    ret_exp      = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h700};
    top_after_cr = 32'h94;
`else
    ret_exp      = '{32'h700, 32'h700, 32'h700, 32'h700, 32'h700};
    top_after_cr = 32'h700;
`endif
    aresetn = 1'b0;
    if_pc   = 32'h100;
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_mispredict", 32'(ex_mispredict), 32'd0);
    check("rst_perf_br", perf_branches, 32'd0);
    check("rst_perf_mis", perf_mispredicts, 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // BHT training at 0x100 (idx 0), target 0x80
    drive(1'b1, 32'h100, 1, 1'b1, 32'h80, 1'b0, 32'h0);
    check("br1_mispredict", 32'(ex_mispredict), 32'd1);
    check("br1_no_bypass", 32'(pred_taken), 32'd0);
    tick();
    drive(1'b1, 32'h100, 1, 1'b1, 32'h80, 1'b1, 32'h80);
    check("br2_pred_taken", 32'(pred_taken), 32'd1);
    check("br2_pred_target", pred_target, 32'h80);
    check("br2_mispredict", 32'(ex_mispredict), 32'd0);
    tick();
    drive(1'b1, 32'h100, 1, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt1_pred_taken", 32'(pred_taken), 32'd1);
    check("nt1_mispredict", 32'(ex_mispredict), 32'd1);
    tick();
    drive(1'b1, 32'h100, 1, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt2_pred_taken", 32'(pred_taken), 32'd1);
    tick();
    drive(1'b0, 32'h100, 0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("nt_final_pred", 32'(pred_taken), 32'd0);
    check("invalid_no_mispredict", 32'(ex_mispredict), 32'd0);
    check("nt_btb_valid", 32'(dut.btb_valid[0]), 32'd1);
    check("nt_bht", 32'(dut.bht[0]), 32'd1);
    check("nt_perf_br", perf_branches, 32'd4);
    check("nt_perf_mis", perf_mispredicts, 32'd3);
    tick();

    // Alias at 0x200 shares idx 0 with 0x100
    drive(1'b1, 32'h100, 1, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h200, 0, 1'b0, 32'h0, 1'b1, 32'h80);
    check("alias_pre_pred", 32'(pred_taken), 32'd1);
    check("alias_mispredict", 32'(ex_mispredict), 32'd1);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("alias_invalidated", 32'(pred_taken), 32'd0);
    check("alias_perf_br", perf_branches, 32'd5);
    check("alias_perf_mis", perf_mispredicts, 32'd5);

    // RAS: train a ret at 0x604, then five calls
    if_pc = 32'h604;
    drive(1'b1, 32'h604, 4, 1'b1, 32'h700, 1'b0, 32'h0);
    check("ret_train_miss", 32'(pred_taken), 32'd0);
    check("ret_train_mispredict", 32'(ex_mispredict), 32'd1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'(k * 16), 3, 1'b1, 32'h400, 1'b1, 32'h400);
      check("call_mispredict", 32'(ex_mispredict), 32'd0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h604, 4, 1'b1, 32'h700, 1'b1, 32'h700);
      check("ret_pred_taken", 32'(pred_taken), 32'd1);
      check("ret_pred_target", pred_target, ret_exp[k]);
      tick();
    end
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("ras_empty_fallback", pred_target, 32'h700);
`ifdef BP_RAS_EN
    check("ras_empty_count", 32'(dut.ras_count), 32'd0);
`endif
    drive(1'b1, 32'h80, 3, 1'b1, 32'h400, 1'b1, 32'h400);
    tick();
    drive(1'b1, 32'h90, 5, 1'b1, 32'h500, 1'b1, 32'h500);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("call_ret_top", pred_target, top_after_cr);
    check("ras_perf_br", perf_branches, 32'd18);
    check("ras_perf_mis", perf_mispredicts, 32'd6);

    // Jump target mismatch
    if_pc = 32'h300;
    drive(1'b1, 32'h300, 2, 1'b1, 32'h200, 1'b1, 32'h1FC);
    check("jump_mispredict", 32'(ex_mispredict), 32'd1);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("jump_pred_taken", 32'(pred_taken), 32'd1);
    check("jump_pred_target", pred_target, 32'h200);
    check("jump_perf_mis", perf_mispredicts, 32'd7);

    // Saturation of perf_branches
    force dut.perf_branches_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_branches_q;
    drive(1'b1, 32'h500, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("perf_br_saturate", perf_branches, 32'hFFFF_FFFF);
    check("perf_mis_hold", perf_mispredicts, 32'd7);

    // Asynchronous reset mid-update
    drive(1'b1, 32'h100, 1, 1'b1, 32'h80, 1'b0, 32'h0);
    check("pre_rst_pred", 32'(pred_taken), 32'd1);
    check("pre_rst_mispredict", 32'(ex_mispredict), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_pred", 32'(pred_taken), 32'd0);
    check("mid_rst_mispredict", 32'(ex_mispredict), 32'd0);
    check("mid_rst_perf_br", perf_branches, 32'd0);
    check("mid_rst_perf_mis", perf_mispredicts, 32'd0);
    check("mid_rst_bht", 32'(dut.bht[0]), 32'd1);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    aresetn = 1'b1;
    tick();
    check("post_rst_pred", 32'(pred_taken), 32'd0);
    check("post_rst_perf_br", perf_branches, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bpred_unit.md
# bpred_unit

Parametrised branch prediction unit for the five-stage RV32I pipeline. It combines into one block a direct-mapped table of 2-bit saturating counters (BHT), a tagged direct-mapped branch target buffer (BTB) with a type field, an optional return address stack (RAS), and 32-bit performance counters. It is looked up combinationally with the IF-stage PC and trained from the EX stage.

## Interface
Parameters:
- PC_WIDTH, 32, instruction address width.
- IDX_BITS, 6, index width; BHT/BTB depth = 2^IDX_BITS.
- TAG_BITS, 8, BTB tag width.
- RAS_DEPTH, 4, return stack entries (power of two, >= 2).

Ports:
- aclk  in  1  clock; single clock domain.
- aresetn  in  1  asynchronous active-low reset.
- if_pc  in  PC_WIDTH  fetch address.
- pred_taken  out  1  predict redirect for if_pc.
- pred_target  out  PC_WIDTH  predicted next PC; valid when pred_taken=1.
- ex_valid  in  1  EX-stage instruction is valid and not flushed.
- ex_pc  in  PC_WIDTH  EX-stage instruction address.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  jal/jalr.
- ex_is_call  in  1  jump writing x1/x5.
- ex_is_ret  in  1  jalr reading x1/x5 with rd=x0.
- ex_taken  in  1  resolved outcome; 1 for every jump.
- ex_target  in  PC_WIDTH  resolved target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  PC_WIDTH  predicted target carried down the pipe.
- ex_mispredict  out  1  redirect required (combinational).
- perf_branches  out  32  resolved branch/jump count.
- perf_mispredicts  out  32  mispredict count.

## Operation
- idx = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- BTB entry fields: valid, tag, target, type. Type encoding: 00 = branch, 01 = jump, 10 = ret.
- Lookup: hit = valid && tag match.
  - pred_taken = hit && (type != 00 || bht[idx][1]).
  - pred_target = RAS top if type=10, RAS non-empty and the RAS is compiled in; otherwise the BTB target.
- ex_mispredict = ex_valid && one of:
  - (branch|jump) && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
  - !(branch|jump) && ex_pred_taken (alias case).
- Updates, when ex_valid:
  - BHT, branches only: taken increments and not-taken decrements the counter at idx(ex_pc), saturating at 11/00.
  - BTB write when (branch|jump) && ex_taken: valid=1, tag, target=ex_target, type = ret ? 10 : jump ? 01 : 00.
  - Not-taken branch: BTB entry is left unchanged.
  - Alias case: BTB entry at idx(ex_pc) is invalidated.
- RAS updates (architectural, at EX):
  - Call pushes ex_pc+4.
  - Ret pops.
  - Call and ret together: top is replaced with ex_pc+4; occupancy unchanged.
  - Push when full: circular overwrite of the oldest entry; occupancy saturates at RAS_DEPTH.
  - Pop when empty: no change.
- Performance counters:
  - perf_branches increments on ex_valid && (branch|jump).
  - perf_mispredicts increments on ex_mispredict.
  - Both saturate at 0xFFFFFFFF.
- ex_valid=0: no state changes and ex_mispredict=0.

## Timing
- Lookup is combinational: same-cycle pred_taken/pred_target from if_pc, no added latency.
- Updates commit on the aclk rising edge and are visible to lookup in the next cycle.
- Same-index read and write in one cycle: lookup returns the pre-update value; no bypass.
- Reset (asynchronous, any time including mid-update) sets:
  - all BHT counters to 01 (weakly not-taken);
  - all BTB valid bits to 0;
  - RAS pointer and occupancy to 0;
  - perf counters to 0.
- Output values in reset: pred_taken=0, ex_mispredict=0 (ex_valid is also held 0 during reset).
- BTB target/tag storage needs no reset.

## Configuration
- BP_RAS_EN defined:
  - RAS storage and logic are present;
  - type-10 hits use the RAS top when the RAS is non-empty.
- BP_RAS_EN undefined:
  - no RAS is instantiated;
  - ex_is_call is ignored;
  - ex_is_ret only sets BTB type 10;
  - type-10 hits predict the stored BTB target.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, perf counters=0.
- Branch at 0x100, target 0x80, resolved taken on two successive updates -> counter 01→10→11; next lookup gives pred_taken=1, pred_target=0x80. Then two not-taken updates -> pred_taken=0 and the BTB entry is still valid.
- Alias: 0x100 and 0x100+(4<<IDX_BITS) share an index. The second PC with an ALU op and ex_pred_taken=1 -> ex_mispredict=1 and the entry is invalidated.
- BP_RAS_EN: calls at 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4, then a ret hit -> pred_target=0x54. After four pops, a fifth pop leaves the RAS unchanged (empty) and the predictor falls back to the BTB target.
- Jump resolved to 0x200 with ex_pred_target=0x1FC -> ex_mispredict=1 and perf_mispredicts +1. Preload perf_branches=0xFFFFFFFF via force -> it holds 0xFFFFFFFF.
- Assert aresetn low mid-stream with ex_valid=1 -> all outputs at reset values in the same cycle and the tables are cleared.
